wb_regfile: RTL and testbench
=============================

Name: wb_regfile

Overview:
- Consumer end of the MEM/WB pipeline register: the writeback stage plus the architectural register file.
- Takes WB-stage fields, selects writeback data (ALU result or load data), and writes the 32x32 MIPS register file.
- Serves the two ID-stage read ports with same-cycle write-through bypass, so no WB-to-ID forwarding is needed elsewhere.
- Keeps a writeback counter for debug and performance use.

Parameters:
- DATA_W, 32, register and data width
- NREGS, 32, number of architectural registers; index width is log2(NREGS) = 5

Ports:
- clk  input  1  pipeline clock; all state updates on the rising edge
- rst  input  1  synchronous, active-high reset
- WB_aluresult  input  32  ALU result from MEM/WB
- WB_memread  input  32  load data from MEM/WB
- WB_writereg  input  5  destination register index
- WB_memtoreg  input  1  1 = write WB_memread; 0 = write WB_aluresult
- WB_regwrite  input  1  writeback enable
- rs_addr  input  5  read port A index (ID stage)
- rt_addr  input  5  read port B index (ID stage)
- rs_data  output  32  read port A data
- rt_data  output  32  read port B data
- wb_data  output  32  selected writeback value (combinational; for debug and forwarding)
- wb_count  output  32  count of committed register writes

Behaviour:
- Writeback mux (combinational): wb_data = WB_memtoreg ? WB_memread : WB_aluresult.
- Commit condition: commit = WB_regwrite && (WB_writereg != 0) && !rst.
- On each rising edge with commit = 1:
  - regs[WB_writereg] <= wb_data.
  - wb_count <= wb_count + 1, wrapping modulo 2^32 (0xFFFFFFFF -> 0).
- Register $0:
  - Never stored.
  - Reads of index 0 always return 0.
  - A write to index 0 is dropped and does not increment wb_count.
- Reads are combinational.
  - rs_data = 0 if rs_addr == 0.
  - Otherwise, rs_data = wb_data if commit && rs_addr == WB_writereg (write-through bypass).
  - Otherwise, rs_data = regs[rs_addr].
  - rt_data follows the same rules with rt_addr.
- Both read ports may hit the same register, and both may bypass in the same cycle.
- Latency:
  - A value written at edge N is visible from the array in cycle N+1.
  - Within cycle N it is visible through the bypass.
- Reset:
  - While rst = 1 at an edge, all regs[1..31] <= 0 and wb_count <= 0.
  - A write pending in that cycle is dropped, since rst takes priority.
  - The bypass is disabled while rst is high, so read ports return array contents (0 after the first reset edge).
  - Reset may be asserted mid-program; the cycle after rst deasserts behaves as a fresh start.
- X-handling: if WB_regwrite = 0, the values of WB_writereg and the data inputs do not affect state.
- No other state and no stall input; the upstream pipeline guarantees one writeback per cycle at most.

Decomposition:
- Shared package (mips_pkg) holds:
  - DATA_W and REG_IDX_W (5)
  - REG_ZERO (5'd0)
  - Named register indices used by benches (e.g. REG_RA = 31)
- One natural sub-module: regfile_2r1w.
  - Bare storage array: two async read ports, one sync write port, $0 hardwired.
  - wb_regfile wraps it with the writeback mux, bypass, commit gating and counter.

Test Plan:
1. Reset: hold rst 2 cycles, then read rs_addr = 5, rt_addr = 31 -> rs_data = rt_data = 0, wb_count = 0.
2. ALU writeback:
   - Stimulus: WB_regwrite = 1, WB_memtoreg = 0, WB_aluresult = 0x0000_00AB, WB_writereg = 8.
   - Same cycle, rs_addr = 8 -> rs_data = 0xAB via bypass.
   - Next cycle, with regwrite = 0 -> rs_data = 0xAB from array, wb_count = 1.
3. Load writeback: WB_memtoreg = 1, WB_memread = 0xDEAD_BEEF, WB_aluresult = 0x1234, WB_writereg = 9 -> next cycle rt_addr = 9 gives 0xDEADBEEF.
4. $0 write: WB_regwrite = 1, WB_writereg = 0, WB_aluresult = 0xFFFF_FFFF -> rs_addr = 0 reads 0 in the same and next cycle; wb_count unchanged.
5. Reset mid-write:
   - Stimulus: rst = 1 together with a write of 0x55 to reg 10.
   - Same cycle, rs_addr = 10 does not return 0x55.
   - After rst = 0, reg 10 reads 0 and wb_count = 0.
6. Counter wrap and dual bypass:
   - Force wb_count to 0xFFFF_FFFF via 2^32-1 writes, or a bench hierarchical preload.
   - Write 0x77 to reg 3 with rs_addr = rt_addr = 3 -> both ports read 0x77 in the same cycle.
   - wb_count wraps to 0 at the edge.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS datapath constants: widths, the hardwired zero register and
// named register indices.
package mips_pkg;

  localparam int DATA_W    = 32;
  localparam int NREGS     = 32;
  localparam int REG_IDX_W = $clog2(NREGS);

  localparam logic [REG_IDX_W-1:0] REG_ZERO = 5'd0;
  localparam logic [REG_IDX_W-1:0] REG_V1   = 5'd3;
  localparam logic [REG_IDX_W-1:0] REG_T0   = 5'd8;
  localparam logic [REG_IDX_W-1:0] REG_T1   = 5'd9;
  localparam logic [REG_IDX_W-1:0] REG_T2   = 5'd10;
  localparam logic [REG_IDX_W-1:0] REG_RA   = 5'd31;

endpackage

// File: rtl/regfile_2r1w.sv
// Bare architectural register storage: two asynchronous read ports and one
// synchronous write port. Register $0 is hardwired to zero.
module regfile_2r1w
  import mips_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 we,
  input  logic [REG_IDX_W-1:0] waddr,
  input  logic [DATA_W-1:0]    wdata,
  input  logic [REG_IDX_W-1:0] raddr_a,
  input  logic [REG_IDX_W-1:0] raddr_b,
  output logic [DATA_W-1:0]    rdata_a,
  output logic [DATA_W-1:0]    rdata_b
);

  logic [DATA_W-1:0] mem [NREGS];

  // NOTE: this array is reset on purpose: software relies on every register
  // reading zero after reset, so it cannot be left as plain RAM.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) mem[i] <= '0;
    end else if (we && (waddr != REG_ZERO)) begin
      // NOTE: non-blocking assignment for all clocked state, so every
      // register samples pre-edge values regardless of statement order.
      mem[waddr] <= wdata;
    end
  end

  assign rdata_a = (raddr_a == REG_ZERO) ? '0 : mem[raddr_a];
  assign rdata_b = (raddr_b == REG_ZERO) ? '0 : mem[raddr_b];

endmodule

// File: rtl/wb_regfile.sv
// Writeback stage plus register file: selects writeback data, commits it,
// serves two ID read ports with write-through bypass and counts commits.
module wb_regfile
  import mips_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_W-1:0]    WB_aluresult,
  input  logic [DATA_W-1:0]    WB_memread,
  input  logic [REG_IDX_W-1:0] WB_writereg,
  input  logic                 WB_memtoreg,
  input  logic                 WB_regwrite,
  input  logic [REG_IDX_W-1:0] rs_addr,
  input  logic [REG_IDX_W-1:0] rt_addr,
  output logic [DATA_W-1:0]    rs_data,
  output logic [DATA_W-1:0]    rt_data,
  output logic [DATA_W-1:0]    wb_data,
  output logic [DATA_W-1:0]    wb_count
);

  logic              commit;
  logic [DATA_W-1:0] arr_rs, arr_rt;
  logic [DATA_W-1:0] count_q;

  assign wb_data = WB_memtoreg ? WB_memread : WB_aluresult;
  assign commit  = WB_regwrite && (WB_writereg != REG_ZERO) && !rst;

  regfile_2r1w u_regs (
    .clk     (clk),
    .rst     (rst),
    .we      (commit),
    .waddr   (WB_writereg),
    .wdata   (wb_data),
    .raddr_a (rs_addr),
    .raddr_b (rt_addr),
    .rdata_a (arr_rs),
    .rdata_b (arr_rt)
  );

  // Same-cycle bypass lets ID see the value being written this edge.
  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    rs_data = arr_rs;
    rt_data = arr_rt;
    if (commit && (rs_addr == WB_writereg)) rs_data = wb_data;
    if (commit && (rt_addr == WB_writereg)) rt_data = wb_data;
  end

  always_ff @(posedge clk) begin
    if (rst)         count_q <= '0;
    else if (commit) count_q <= count_q + 1'b1;
  end

  assign wb_count = count_q;

endmodule

// File: tb/tb_wb_regfile.sv
// Directed self-checking bench for wb_regfile: reset, ALU/load writeback,
// $0 handling, reset during a write, dual bypass and counter wrap.
module tb_wb_regfile;
  import mips_pkg::*;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [DATA_W-1:0]    WB_aluresult, WB_memread;
  logic [REG_IDX_W-1:0] WB_writereg;
  logic                 WB_memtoreg, WB_regwrite;
  logic [REG_IDX_W-1:0] rs_addr, rt_addr;
  logic [DATA_W-1:0]    rs_data, rt_data, wb_data, wb_count;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  wb_regfile dut (
    .clk          (clk),
    .rst          (rst),
    .WB_aluresult (WB_aluresult),
    .WB_memread   (WB_memread),
    .WB_writereg  (WB_writereg),
    .WB_memtoreg  (WB_memtoreg),
    .WB_regwrite  (WB_regwrite),
    .rs_addr      (rs_addr),
    .rt_addr      (rt_addr),
    .rs_data      (rs_data),
    .rt_data      (rt_data),
    .wb_data      (wb_data),
    .wb_count     (wb_count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance to just after the next rising edge; inputs change there.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic wb(input logic en, input logic m2r, input logic [4:0] idx,
                    input logic [31:0] alu, input logic [31:0] mem);
    WB_regwrite  = en;
    WB_memtoreg  = m2r;
    WB_writereg  = idx;
    WB_aluresult = alu;
    WB_memread   = mem;
  endtask

  initial begin
    rst = 1'b1;
    rs_addr = '0;
    rt_addr = '0;
    wb(1'b0, 1'b0, REG_ZERO, '0, '0);

    // 1. reset held for two edges
    next_cycle();
    next_cycle();
    rst = 1'b0;
    rs_addr = 5'd5;
    rt_addr = REG_RA;
    #1;
    check("reset_rs", rs_data, 32'h0);
    check("reset_rt", rt_data, 32'h0);
    check("reset_count", wb_count, 32'h0);

    // 2. ALU writeback with same-cycle bypass
    wb(1'b1, 1'b0, REG_T0, 32'h0000_00AB, 32'h0000_0000);
    rs_addr = REG_T0;
    #1;
    check("alu_wb_data", wb_data, 32'h0000_00AB);
    check("alu_bypass_rs", rs_data, 32'h0000_00AB);
    next_cycle();
    // regwrite low: other data on the bus must not disturb reg 8
    wb(1'b0, 1'b0, REG_T0, 32'h0000_0BAD, 32'h0000_0000);
    #1;
    check("alu_array_rs", rs_data, 32'h0000_00AB);
    check("alu_count", wb_count, 32'd1);

    // 3. load writeback selects memread
    wb(1'b1, 1'b1, REG_T1, 32'h0000_1234, 32'hDEAD_BEEF);
    #1;
    check("load_wb_data", wb_data, 32'hDEAD_BEEF);
    next_cycle();
    wb(1'b0, 1'b0, REG_T0, 32'h0000_0BAD, 32'h0);
    rt_addr = REG_T1;
    #1;
    check("load_array_rt", rt_data, 32'hDEAD_BEEF);
    check("noen_keeps_rs", rs_data, 32'h0000_00AB);
    check("load_count", wb_count, 32'd2);

    // 4. write to $0 is dropped
    wb(1'b1, 1'b0, REG_ZERO, 32'hFFFF_FFFF, 32'h0);
    rs_addr = REG_ZERO;
    #1;
    check("zero_same_cycle", rs_data, 32'h0);
    next_cycle();
    wb(1'b0, 1'b0, REG_ZERO, 32'h0, 32'h0);
    #1;
    check("zero_next_cycle", rs_data, 32'h0);
    check("zero_count", wb_count, 32'd2);

    // bypass applies only to the matching port
    wb(1'b1, 1'b0, REG_RA, 32'h0000_1357, 32'h0);
    rs_addr = REG_T0;
    rt_addr = REG_RA;
    #1;
    check("ra_no_bypass_rs", rs_data, 32'h0000_00AB);
    check("ra_bypass_rt", rt_data, 32'h0000_1357);
    next_cycle();
    wb(1'b0, 1'b0, REG_ZERO, 32'h0, 32'h0);
    #1;
    check("ra_array_rt", rt_data, 32'h0000_1357);
    check("ra_count", wb_count, 32'd3);

    // 5. reset takes priority over a pending write
    rst = 1'b1;
    wb(1'b1, 1'b0, REG_T2, 32'h0000_0055, 32'h0);
    rs_addr = REG_T2;
    rt_addr = REG_T1;
    #1;
    check("rst_no_bypass_rs", rs_data, 32'h0);
    check("rst_array_rt", rt_data, 32'hDEAD_BEEF);
    next_cycle();
    rst = 1'b0;
    wb(1'b0, 1'b0, REG_ZERO, 32'h0, 32'h0);
    #1;
    check("post_rst_r10", rs_data, 32'h0);
    check("post_rst_r9", rt_data, 32'h0);
    check("post_rst_count", wb_count, 32'h0);
    rt_addr = REG_RA;
    #1;
    check("post_rst_r31", rt_data, 32'h0);

    // 6. counter wrap with both ports bypassing the same register
    force dut.count_q = 32'hFFFF_FFFF;
    #1;
    release dut.count_q;
    #1;
    check("preload_count", wb_count, 32'hFFFF_FFFF);
    wb(1'b1, 1'b0, REG_V1, 32'h0000_0077, 32'h0);
    rs_addr = REG_V1;
    rt_addr = REG_V1;
    #1;
    check("dual_bypass_rs", rs_data, 32'h0000_0077);
    check("dual_bypass_rt", rt_data, 32'h0000_0077);
    next_cycle();
    wb(1'b0, 1'b0, REG_ZERO, 32'h0, 32'h0);
    #1;
    check("wrap_count", wb_count, 32'h0);
    check("wrap_array_rs", rs_data, 32'h0000_0077);
    check("wrap_array_rt", rt_data, 32'h0000_0077);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
